// File: rtl/snake_pkg.sv
// snake_pkg: shared direction codes, FSM states and default grid bounds for the snake engines
package snake_pkg;
   localparam logic [3:0] DIR_LEFT  = 4'b0001;
   localparam logic [3:0] DIR_RIGHT = 4'b0010;
   localparam logic [3:0] DIR_UP    = 4'b0100;
   localparam logic [3:0] DIR_DOWN  = 4'b1000;
   localparam int DEF_X_MIN = 10;
   localparam int DEF_X_MAX = 69;
   localparam int DEF_Y_MIN = 10;
   localparam int DEF_Y_MAX = 49;
   typedef enum logic [1:0] {IDLE, SCAN, DEAD} state_t;
   // Heading that would fold the snake back onto its own neck (left<->right, up<->down)
   function automatic logic [3:0] reverse_of(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction
endpackage

// File: rtl/snake_dir_filter.sv
// snake_dir_filter: keeps the current heading, accepting only one-hot, non-reversing requests
module snake_dir_filter
   import snake_pkg::*;
(
   input  logic       VGA_clk,
   input  logic       rst,
   input  logic       i_restart,
   input  logic       i_en,
   input  logic [3:0] i_dir,
   output logic [3:0] o_dir
);
   logic [3:0] r_dir;
   logic       w_ok;
   assign w_ok  = $onehot(i_dir) && (i_dir != reverse_of(r_dir));
   assign o_dir = r_dir;
   // Hold the last legal heading; a fresh game points the snake down
   always_ff @(posedge VGA_clk or posedge rst)
      if (rst) r_dir <= DIR_DOWN;
      else if (i_restart) r_dir <= DIR_DOWN;
      else if (i_en && w_ok) r_dir <= i_dir;
endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: ring-buffer snake body with move, wall/self collision and pixel hit query (SNAKE_WRAP_EN makes walls wrap)
module snake_body_engine
   import snake_pkg::*;
#(
   parameter int MAX_LEN   = 128,
   parameter int COORD_W   = 7,
   parameter int X_MIN     = DEF_X_MIN,
   parameter int X_MAX     = DEF_X_MAX,
   parameter int Y_MIN     = DEF_Y_MIN,
   parameter int Y_MAX     = DEF_Y_MAX,
   parameter int GROW_STEP = 4,
   parameter int START_X   = 30,
   parameter int START_Y   = 25
)(
   input  logic                     VGA_clk,
   input  logic                     rst,
   input  logic                     restart,
   input  logic                     step,
   input  logic [3:0]               dir_in,
   input  logic                     grow,
   input  logic [COORD_W-1:0]       pix_x,
   input  logic [COORD_W-1:0]       pix_y,
   output logic                     pix_hit,
   output logic [COORD_W-1:0]       head_x,
   output logic [COORD_W-1:0]       head_y,
   output logic [$clog2(MAX_LEN):0] length,
   output logic                     alive,
   output logic                     wall_hit,
   output logic                     self_hit,
   output logic                     busy,
   output logic                     step_done
);
   localparam int PW = $clog2(MAX_LEN);
   localparam int LW = PW + 1;
   localparam logic [COORD_W-1:0] LX_MIN = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] LX_MAX = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] LY_MIN = COORD_W'(Y_MIN);
   localparam logic [COORD_W-1:0] LY_MAX = COORD_W'(Y_MAX);
   localparam logic [COORD_W-1:0] SX     = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] SY     = COORD_W'(START_Y);
   localparam logic [LW-1:0]      L_MAX  = LW'(MAX_LEN);
   localparam logic [LW:0]        L_GROW = (LW+1)'(GROW_STEP);
   logic [COORD_W-1:0] r_bx [MAX_LEN];
   logic [COORD_W-1:0] r_by [MAX_LEN];
   logic [COORD_W-1:0] r_hx, r_hy, w_mx, w_my, w_nx, w_ny;
   logic [PW-1:0]      r_hp, r_idx, w_sp, w_wp;
   logic [LW-1:0]      r_len, r_pend, w_pend;
   logic [LW:0]        w_psum;
   logic [3:0]         w_dir;
   state_t             r_state, w_next;
   logic               r_wall, r_self, r_done, r_pix, w_pix;
   logic               w_step, w_wall, w_inc, w_match, w_last;

   snake_dir_filter u_dir (
      .VGA_clk   (VGA_clk),
      .rst       (rst),
      .i_restart (restart),
      .i_en      (r_state != DEAD),
      .i_dir     (dir_in),
      .o_dir     (w_dir)
   );

   assign w_step = (r_state == IDLE) && step;
   assign w_mx   = (w_dir == DIR_LEFT) ? r_hx - 1'b1 : (w_dir == DIR_RIGHT) ? r_hx + 1'b1 : r_hx;
   assign w_my   = (w_dir == DIR_UP) ? r_hy - 1'b1 : (w_dir == DIR_DOWN) ? r_hy + 1'b1 : r_hy;
`ifdef SNAKE_WRAP_EN
   assign w_nx   = (w_mx == LX_MIN) ? LX_MAX - 1'b1 : (w_mx == LX_MAX) ? LX_MIN + 1'b1 : w_mx;
   assign w_ny   = (w_my == LY_MIN) ? LY_MAX - 1'b1 : (w_my == LY_MAX) ? LY_MIN + 1'b1 : w_my;
   assign w_wall = 1'b0;
`else
   assign w_nx   = w_mx;
   assign w_ny   = w_my;
   assign w_wall = (w_mx == LX_MIN) || (w_mx == LX_MAX) || (w_my == LY_MIN) || (w_my == LY_MAX);
`endif
   assign w_inc   = (r_pend != '0) && (r_len < L_MAX);
   assign w_psum  = {1'b0, r_pend} - (LW+1)'(w_step && w_inc) + ((grow && r_state != DEAD) ? L_GROW : '0);
   assign w_pend  = (w_psum > {1'b0, L_MAX}) ? L_MAX : w_psum[LW-1:0];
   assign w_sp    = r_hp - r_idx;
   assign w_match = (r_bx[w_sp] == r_hx) && (r_by[w_sp] == r_hy);
   assign w_last  = ({1'b0, r_idx} == r_len - 1'b1);
   assign w_wp    = restart ? '0 : w_step ? r_hp + 1'b1 : r_hp;

   assign head_x    = r_hx;
   assign head_y    = r_hy;
   assign length    = r_len;
   assign wall_hit  = r_wall;
   assign self_hit  = r_self;
   assign step_done = r_done;
   assign pix_hit   = r_pix;

   // State register
   always_ff @(posedge VGA_clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= restart ? IDLE : w_next;

   // Next state: a move dies on a wall, finishes at once for a lone head, or starts the body scan
   always_comb begin
      w_next = r_state;
      if (w_step) w_next = w_wall ? DEAD : (r_len == LW'(1) && !w_inc) ? IDLE : SCAN;
      else if (r_state == SCAN) w_next = w_match ? DEAD : w_last ? IDLE : SCAN;
   end

   // Outputs decoded from state
   always_comb begin
      busy  = (r_state == SCAN);
      alive = (r_state != DEAD);
   end

   // Head, pointer, length/growth accounting, sticky death flags and the done pulse
   always_ff @(posedge VGA_clk or posedge rst)
      if (rst) begin
         r_hx   <= SX;
         r_hy   <= SY;
         r_hp   <= '0;
         r_idx  <= '0;
         r_len  <= LW'(1);
         r_pend <= '0;
         r_wall <= 1'b0;
         r_self <= 1'b0;
         r_done <= 1'b0;
         r_pix  <= 1'b0;
      end else if (restart) begin
         r_hx   <= SX;
         r_hy   <= SY;
         r_hp   <= '0;
         r_idx  <= '0;
         r_len  <= LW'(1);
         r_pend <= '0;
         r_wall <= 1'b0;
         r_self <= 1'b0;
         r_done <= 1'b0;
         r_pix  <= 1'b0;
      end else begin
         r_pend <= w_pend;
         r_pix  <= w_pix;
         r_done <= 1'b0;
         if (w_step) begin
            r_hx   <= w_nx;
            r_hy   <= w_ny;
            r_hp   <= r_hp + 1'b1;
            r_len  <= r_len + LW'(w_inc);
            r_idx  <= PW'(1);
            r_wall <= w_wall;
            r_done <= !w_wall && r_len == LW'(1) && !w_inc;
         end else if (r_state == SCAN) begin
            r_idx  <= r_idx + 1'b1;
            r_self <= w_match;
            r_done <= !w_match && w_last;
         end
      end

   // Body ring: a move writes the new head one slot ahead; other cycles refresh the head slot so it is valid after (re)start
   always_ff @(posedge VGA_clk) begin
      r_bx[w_wp] <= restart ? SX : w_step ? w_nx : r_hx;
      r_by[w_wp] <= restart ? SY : w_step ? w_ny : r_hy;
   end

   // Pixel query: slot k is live when it lies less than length slots behind the head
   always_comb begin
      w_pix = 1'b0;
      for (int k = 0; k < MAX_LEN; k++)
         w_pix = w_pix | ((r_bx[k] == pix_x) && (r_by[k] == pix_y) && ({1'b0, r_hp - PW'(k)} < r_len));
   end
endmodule
